// File: rtl/slice_capture_bank.sv
// Captures one ival word, loads NCH MSB-aligned SW-bit slices into a shadow bank and commits
// them atomically to out_data. Optional parity outputs: define SLICE_CAPTURE_PARITY_EN.
module slice_capture_bank #(
    parameter int unsigned IW       = 32,
    parameter int unsigned SW       = 4,
    parameter int unsigned NCH      = 4,
    parameter bit          RST_ONES = 1'b1,
    parameter int unsigned CNT_W    = 8
) (
    input  logic                  sysclk,
    input  logic                  reset,
    input  logic [IW-1:0]         ival,
    input  logic                  start,
    output logic                  in_ready,
    output logic                  busy,
    output logic [NCH*SW-1:0]     out_data,
    output logic                  done,
    output logic [CNT_W-1:0]      commit_cnt
`ifdef SLICE_CAPTURE_PARITY_EN
    ,
    output logic [NCH-1:0]        out_par
`endif
);

    localparam int unsigned BW   = NCH * SW;
    localparam int unsigned IDXW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [BW-1:0] FILL = RST_ONES ? {BW{1'b1}} : {BW{1'b0}};

    generate
        if (NCH < 1 || BW > IW) begin : g_bad_cfg
            $error("slice_capture_bank: NCH*SW must not exceed IW");
        end
        // Bits of ival below the sliced region never reach any register.
        if (IW > BW) begin : g_low_bits
            logic unused_low_bits;
            assign unused_low_bits = ^ival[IW-BW-1:0];
        end
    endgenerate

    typedef enum logic [1:0] {StIdle, StLoad, StCommit} state_e;

    state_e             state_q, state_d;
    logic [IDXW-1:0]    idx_q, idx_d;
    logic [BW-1:0]      hold_q, hold_d;
    logic [BW-1:0]      shadow_q, shadow_d;
    logic [BW-1:0]      out_q, out_d;
    logic               done_q, done_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    always_ff @(posedge sysclk) begin
        if (reset) begin
            state_q  <= StIdle;
            idx_q    <= '0;
            hold_q   <= '0;
            shadow_q <= FILL;
            out_q    <= FILL;
            done_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            hold_q   <= hold_d;
            shadow_q <= shadow_d;
            out_q    <= out_d;
            done_q   <= done_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        hold_d   = hold_q;
        shadow_d = shadow_q;
        out_d    = out_q;
        done_d   = 1'b0;
        cnt_d    = cnt_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    hold_d  = ival[IW-1 -: BW];
                    idx_d   = '0;
                    state_d = StLoad;
                end
            end
            StLoad: begin
                for (int k = 0; k < NCH; k++) begin
                    if (idx_q == IDXW'(k)) begin
                        shadow_d[BW-1-k*SW -: SW] = hold_q[BW-1-k*SW -: SW];
                    end
                end
                if (idx_q == IDXW'(NCH - 1)) begin
                    state_d = StCommit;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            StCommit: begin
                out_d   = shadow_q;
                done_d  = 1'b1;
                cnt_d   = cnt_q + 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign in_ready   = (state_q == StIdle);
    assign busy       = (state_q != StIdle);
    assign out_data   = out_q;
    assign done       = done_q;
    assign commit_cnt = cnt_q;

`ifdef SLICE_CAPTURE_PARITY_EN
    // Derived from the committed register, so it moves on exactly the same edges.
    always_comb begin
        out_par = '0;
        for (int k = 0; k < NCH; k++) begin
            out_par[k] = ^out_q[BW-1-k*SW -: SW];
        end
    end
`else
    // Parity outputs are not built in this configuration.
`endif

endmodule

// File: tb/tb_slice_capture_bank.sv
// Directed bench for slice_capture_bank: transfer-level model compared every cycle, plus
// literal checks. Builds with or without SLICE_CAPTURE_PARITY_EN.
module tb_slice_capture_bank;

    localparam int unsigned IW  = 32;
    localparam int unsigned SW  = 4;
    localparam int unsigned NCH = 4;
    localparam int unsigned BW  = NCH * SW;

    logic          sysclk;
    logic          reset;
    logic [IW-1:0] ival;
    logic          start;
    logic          in_ready, busy, done;
    logic [BW-1:0] out_data;
    logic [7:0]    commit_cnt;
    logic          in_ready2, busy2, done2;
    logic [BW-1:0] out_data2;
    logic [1:0]    commit_cnt2;
`ifdef SLICE_CAPTURE_PARITY_EN
    logic [NCH-1:0] out_par, out_par2;
`endif

    slice_capture_bank #(.IW(IW), .SW(SW), .NCH(NCH), .RST_ONES(1'b1), .CNT_W(8)) dut (
        .sysclk     (sysclk),
        .reset      (reset),
        .ival       (ival),
        .start      (start),
        .in_ready   (in_ready),
        .busy       (busy),
        .out_data   (out_data),
        .done       (done),
        .commit_cnt (commit_cnt)
`ifdef SLICE_CAPTURE_PARITY_EN
        ,
        .out_par    (out_par)
`endif
    );

    slice_capture_bank #(.IW(IW), .SW(SW), .NCH(NCH), .RST_ONES(1'b1), .CNT_W(2)) dut2 (
        .sysclk     (sysclk),
        .reset      (reset),
        .ival       (ival),
        .start      (start),
        .in_ready   (in_ready2),
        .busy       (busy2),
        .out_data   (out_data2),
        .done       (done2),
        .commit_cnt (commit_cnt2)
`ifdef SLICE_CAPTURE_PARITY_EN
        ,
        .out_par    (out_par2)
`endif
    );

    initial sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Transfer-level model: an accepted word appears NCH+1 edges later.
    int            m_rem = 0;
    logic [BW-1:0] m_pend;
    logic [BW-1:0] m_out;
    int            m_cnt = 0;
    logic          m_done = 1'b0;
    bit            m_ok = 1'b0;
    int            cyc = 0;
    int            done_total = 0;
    int            done_cyc_q[$];
    int            cnt2_q[$];
    logic [BW-1:0] val_q[$];

    function automatic logic [NCH-1:0] par_of(input logic [BW-1:0] v);
        logic [NCH-1:0] p = '0;
        for (int k = 0; k < NCH; k++) p[k] = ^v[BW-1-k*SW -: SW];
        return p;
    endfunction

    // Inputs change 1 time unit after the negedge, so at the negedge they still hold
    // what the preceding posedge sampled.
    always @(negedge sysclk) begin
        cyc++;
        if (reset) begin
            m_rem  = 0;
            m_out  = {BW{1'b1}};
            m_cnt  = 0;
            m_done = 1'b0;
            m_ok   = 1'b1;
        end else begin
            m_done = 1'b0;
            if (m_rem > 0) begin
                m_rem--;
                if (m_rem == 0) begin
                    m_out  = m_pend;
                    m_done = 1'b1;
                    m_cnt++;
                end
            end else if (start) begin
                m_pend = ival[IW-1 -: BW];
                m_rem  = NCH + 1;
            end
        end
        if (m_ok) begin
            check("out_data", 32'(out_data), 32'(m_out));
            check("done", 32'(done), 32'(m_done));
            check("busy", 32'(busy), 32'(m_rem != 0));
            check("in_ready", 32'(in_ready), 32'(m_rem == 0));
            check("commit_cnt", 32'(commit_cnt), 32'(m_cnt % 256));
            check("commit_cnt_w2", 32'(commit_cnt2), 32'(m_cnt % 4));
            check("out_data_w2", 32'(out_data2), 32'(m_out));
`ifdef SLICE_CAPTURE_PARITY_EN
            check("out_par", 32'(out_par), 32'(par_of(m_out)));
`endif
        end
        if (done) begin
            done_total++;
            done_cyc_q.push_back(cyc);
            cnt2_q.push_back(int'(commit_cnt2));
            val_q.push_back(out_data);
        end
    end

    task automatic tick();
        @(negedge sysclk);
        #1;
    endtask

    function automatic logic [IW-1:0] pat(input int i);
        return 32'hA000_0000 ^ (32'(i) * 32'h1357_0000) ^ 32'(i);
    endfunction

    int d0;

    initial begin
        reset = 1'b1;
        start = 1'b0;
        ival  = '0;
        repeat (2) tick();
        reset = 1'b0;
        tick();
        check("rst_out_data", 32'(out_data), 32'h0000_FFFF);
        check("rst_done", 32'(done), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_cnt", 32'(commit_cnt), 32'd0);
`ifdef SLICE_CAPTURE_PARITY_EN
        check("rst_par", 32'(out_par), 32'd0);
`endif

        // Single transfer.
        ival  = 32'hA5C3_1234;
        start = 1'b1;
        tick();
        start = 1'b0;
        ival  = 32'h0BAD_F00D;
        check("e0_busy", 32'(busy), 32'd1);
        repeat (4) tick();
        check("e4_out_held", 32'(out_data), 32'h0000_FFFF);
        tick();
        check("single_out", 32'(out_data), 32'h0000_A5C3);
        check("single_done", 32'(done), 32'd1);
        check("single_cnt", 32'(commit_cnt), 32'd1);
        check("single_busy", 32'(busy), 32'd0);
        tick();
        check("single_done_clr", 32'(done), 32'd0);

        // Reset during LOAD, with start asserted alongside reset.
        ival  = 32'h1234_0000;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        d0    = done_total;
        reset = 1'b1;
        start = 1'b1;
        tick();
        reset = 1'b0;
        start = 1'b0;
        check("midrst_busy", 32'(busy), 32'd0);
        repeat (6) tick();
        check("midrst_no_done", 32'(done_total - d0), 32'd0);
        check("midrst_out", 32'(out_data), 32'h0000_FFFF);
        check("midrst_cnt", 32'(commit_cnt), 32'd0);
        check("midrst_ready", 32'(in_ready), 32'd1);

        // start held high, ival changing every cycle: five back-to-back transfers.
        done_cyc_q.delete();
        cnt2_q.delete();
        val_q.delete();
        start = 1'b1;
        for (int i = 0; i < 30; i++) begin
            ival = pat(i);
            tick();
        end
        start = 1'b0;
        repeat (3) tick();
        check("b2b_commits", 32'(done_cyc_q.size()), 32'd5);
        if (done_cyc_q.size() == 5) begin
            for (int j = 0; j < 5; j++) begin
                check("b2b_value", 32'(val_q[j]), 32'(pat(6 * j) >> 16));
                if (j > 0) check("b2b_spacing", 32'(done_cyc_q[j] - done_cyc_q[j-1]), 32'd6);
            end
            check("w2_cnt0", 32'(cnt2_q[0]), 32'd1);
            check("w2_cnt1", 32'(cnt2_q[1]), 32'd2);
            check("w2_cnt2", 32'(cnt2_q[2]), 32'd3);
            check("w2_cnt3", 32'(cnt2_q[3]), 32'd0);
            check("w2_cnt4", 32'(cnt2_q[4]), 32'd1);
        end
        check("b2b_cnt8", 32'(commit_cnt), 32'd5);

        // Parity-relevant pattern.
        ival  = 32'h7100_0000;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        check("par_out", 32'(out_data), 32'h0000_7100);
`ifdef SLICE_CAPTURE_PARITY_EN
        check("par_bits", 32'(out_par), 32'h0000_0003);
`endif
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
